// File: rtl/fir_hls_drv_pkg.sv
// Shared types and defaults for the fir_hls ap_ctrl_hs initiator and its result FIFO.
package fir_hls_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } drv_state_e;

  localparam int DEF_XW      = 8;
  localparam int DEF_YW      = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 255;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_hls_res_fifo.sv
// Result FIFO: power-of-two depth, wrapping pointers, head word shown combinationally on dout.
module fir_hls_res_fifo
  import fir_hls_drv_pkg::*;
#(
  parameter int YW    = DEF_YW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [YW-1:0]              din,
  output logic [YW-1:0]              dout,
  output logic [fifo_aw(DEPTH):0]    count,
  output logic                       empty
);
  localparam int          AW     = fifo_aw(DEPTH);
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

  logic [YW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_s, pop_s;

  // Guards keep the storage consistent even if a caller misbehaves.
  assign push_s = push && (count_q != FULL_C);
  assign pop_s  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fir_hls_driver.sv
// On-chip ap_ctrl_hs master for fir_hls: one invocation per upstream sample, results
// buffered in a credit-protected FIFO, with a per-invocation watchdog and sticky error.
module fir_hls_driver
  import fir_hls_drv_pkg::*;
#(
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          s_valid,
  input  logic [XW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [YW-1:0] m_data,
  input  logic          m_ready,
  output logic          hls_start,
  output logic [XW-1:0] hls_x,
  input  logic          hls_ready,
  input  logic          hls_done,
  input  logic          hls_idle,
  input  logic [YW-1:0] hls_y,
  input  logic          hls_y_vld,
  output logic          busy,
  output logic          err
);
  localparam int            AW        = fifo_aw(DEPTH);
  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_C    = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WD_LAST_C = WW'(TIMEOUT - 1);

  drv_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          y_seen_q, y_seen_d;
  logic          err_q, err_d;
  logic          s_ready_q, s_ready_d;
  logic          init_q;
  logic          end_s, push_s, pop_s, fifo_empty_s;
  logic [AW:0]   fifo_count_s, count_d_s;
  logic [YW-1:0] fifo_dout_s;
  logic          status_unused_s;

  assign pop_s           = m_ready && !fifo_empty_s;
  assign count_d_s       = fifo_count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  assign status_unused_s = hls_idle;

  fir_hls_res_fifo #(
    .YW    (YW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (hls_y),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // init_q holds s_ready low for the first edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      wd_q      <= '0;
      y_seen_q  <= 1'b0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      wd_q      <= wd_d;
      y_seen_q  <= y_seen_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      init_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    wd_d     = wd_q;
    y_seen_d = y_seen_q;
    err_d    = err_q;
    push_s   = 1'b0;
    end_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        err_d = err_q | hls_y_vld;
        if (s_valid && s_ready_q) begin
          state_d  = ST_START;
          x_d      = s_data;
          wd_d     = '0;
          y_seen_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START, ST_WAIT: begin
        wd_d     = wd_q + WW'(1);
        push_s   = hls_y_vld && !y_seen_q;
        y_seen_d = y_seen_q | hls_y_vld;
        err_d    = err_q | (hls_y_vld && y_seen_q);
        end_s    = (state_q == ST_START) ? (hls_ready && hls_done) : hls_done;
        // A completed invocation that never produced y is a fault; its credit is simply freed.
        if (end_s) begin
          state_d = ST_IDLE;
          err_d   = err_d | (!y_seen_q && !hls_y_vld);
        end else if (wd_q == WD_LAST_C) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if ((state_q == ST_START) && hls_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Returning to IDLE releases the outstanding credit, so only FIFO occupancy matters here.
    s_ready_d = init_q && (state_d == ST_IDLE) && (count_d_s < FULL_C) && !err_d;
  end

  always_comb begin
    hls_start = (state_q == ST_START);
    busy      = (state_q != ST_IDLE);
    hls_x     = x_q;
    s_ready   = s_ready_q;
    err       = err_q;
    m_valid   = !fifo_empty_s;
    m_data    = fifo_dout_s;
  end

endmodule

// File: tb/tb_fir_hls_driver.sv
// Directed bench for fir_hls_driver; the ap_ctrl_hs responder is played step by step.
module tb_fir_hls_driver;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        hls_start;
  logic [7:0]  hls_x;
  logic        hls_ready = 1'b0;
  logic        hls_done = 1'b0;
  logic        hls_idle = 1'b1;
  logic [15:0] hls_y = 16'h0000;
  logic        hls_y_vld = 1'b0;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int rises = 0;
  int r0 = 0;
  logic start_prev = 1'b0;

  fir_hls_driver dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .hls_start (hls_start),
    .hls_x     (hls_x),
    .hls_ready (hls_ready),
    .hls_done  (hls_done),
    .hls_idle  (hls_idle),
    .hls_y     (hls_y),
    .hls_y_vld (hls_y_vld),
    .busy      (busy),
    .err       (err)
  );

  always #5 ap_clk = ~ap_clk;

  // Counts start pulse trains (rising edges of hls_start as seen at clock edges).
  always @(posedge ap_clk) begin
    if (hls_start && !start_prev) rises <= rises + 1;
    start_prev <= hls_start;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserts reset right now (possibly mid-cycle), checks outputs, then releases after an edge.
  task automatic apply_reset;
    ap_rst_n = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0;
    hls_ready = 1'b0; hls_done = 1'b0; hls_y_vld = 1'b0;
    #1;
    chk("rst_outputs", {3'b0, s_ready, m_valid, m_data, hls_start, hls_x, busy, err}, 32'h0);
    tick;
    tick;
    ap_rst_n = 1'b1;
    tick;
    chk("rdy_edge1", {31'b0, s_ready}, 32'h0);
    tick;
    chk("rdy_edge2", {31'b0, s_ready}, 32'h1);
  endtask

  task automatic accept(input logic [7:0] x);
    s_data = x;
    s_valid = 1'b1;
    for (int i = 0; i < 20 && !s_ready; i++) tick;
    chk("acc_ready", {31'b0, s_ready}, 32'h1);
    tick;
    s_valid = 1'b0;
    chk("acc_start", {31'b0, hls_start}, 32'h1);
    chk("acc_x", {24'b0, hls_x}, {24'b0, x});
  endtask

  task automatic finish_same(input logic [15:0] y);
    hls_ready = 1'b1; hls_done = 1'b1; hls_y_vld = 1'b1; hls_y = y;
    tick;
    hls_ready = 1'b0; hls_done = 1'b0; hls_y_vld = 1'b0;
    chk("fin_idle", {30'b0, hls_start, busy}, 32'h0);
  endtask

  initial begin
    apply_reset;

    // 1: single transaction, ready two cycles after start, done+y two cycles later
    r0 = rises;
    accept(8'h05);
    tick;
    chk("t1_start_a", {31'b0, hls_start}, 32'h1);
    chk("t1_x_a", {24'b0, hls_x}, 32'h05);
    tick;
    chk("t1_start_b", {31'b0, hls_start}, 32'h1);
    chk("t1_x_b", {24'b0, hls_x}, 32'h05);
    hls_ready = 1'b1;
    tick;
    hls_ready = 1'b0;
    chk("t1_wait", {30'b0, hls_start, busy}, 32'h1);
    tick;
    hls_done = 1'b1; hls_y_vld = 1'b1; hls_y = 16'h1234;
    tick;
    hls_done = 1'b0; hls_y_vld = 1'b0;
    chk("t1_busy", {31'b0, busy}, 32'h0);
    chk("t1_mvalid", {31'b0, m_valid}, 32'h1);
    chk("t1_mdata", {16'b0, m_data}, 32'h1234);
    chk("t1_sready", {31'b0, s_ready}, 32'h1);
    chk("t1_err", {31'b0, err}, 32'h0);
    chk("t1_one_train", rises, r0 + 1);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("t1_drained", {31'b0, m_valid}, 32'h0);

    // 2: backpressure fills the FIFO, then ordered drain
    for (int v = 1; v <= 4; v++) begin
      accept(8'(v));
      finish_same(16'(10 * v));
    end
    chk("t2_full_sready", {31'b0, s_ready}, 32'h0);
    chk("t2_head", {16'b0, m_data}, 32'd10);
    r0 = rises;
    s_valid = 1'b1; s_data = 8'h05;
    repeat (4) tick;
    chk("t2_no_start", {31'b0, hls_start}, 32'h0);
    chk("t2_no_train", rises, r0);
    chk("t2_still_blocked", {31'b0, s_ready}, 32'h0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("t2_pop_sready", {31'b0, s_ready}, 32'h1);
    chk("t2_order20", {16'b0, m_data}, 32'd20);
    m_ready = 1'b1;
    tick;
    chk("t2_order30", {16'b0, m_data}, 32'd30);
    tick;
    chk("t2_order40", {16'b0, m_data}, 32'd40);
    tick;
    m_ready = 1'b0;
    chk("t2_empty", {31'b0, m_valid}, 32'h0);

    // 3: ready, done and y_vld in the first START cycle; next accept two edges after the first
    accept(8'h07);
    hls_ready = 1'b1; hls_done = 1'b1; hls_y_vld = 1'b1; hls_y = 16'h0070;
    s_valid = 1'b1; s_data = 8'h08;
    tick;
    hls_ready = 1'b0; hls_done = 1'b0; hls_y_vld = 1'b0;
    chk("t3_start_1cyc", {30'b0, hls_start, busy}, 32'h0);
    chk("t3_push", {16'b0, m_data}, 32'h0070);
    chk("t3_mvalid", {31'b0, m_valid}, 32'h1);
    chk("t3_sready", {31'b0, s_ready}, 32'h1);
    tick;
    s_valid = 1'b0;
    chk("t3_next_start", {31'b0, hls_start}, 32'h1);
    chk("t3_next_x", {24'b0, hls_x}, 32'h08);
    finish_same(16'h0080);
    m_ready = 1'b1;
    tick;
    chk("t3_second", {16'b0, m_data}, 32'h0080);
    tick;
    m_ready = 1'b0;
    chk("t3_empty", {31'b0, m_valid}, 32'h0);

    // 5a: y_vld while idle
    hls_y = 16'hdead; hls_y_vld = 1'b1;
    tick;
    hls_y_vld = 1'b0;
    chk("t5a_err", {31'b0, err}, 32'h1);
    chk("t5a_no_push", {31'b0, m_valid}, 32'h0);
    chk("t5a_sready", {31'b0, s_ready}, 32'h0);
    apply_reset;

    // 5b: done without y_vld
    accept(8'h03);
    hls_ready = 1'b1; hls_done = 1'b1;
    tick;
    hls_ready = 1'b0; hls_done = 1'b0;
    chk("t5b_err", {31'b0, err}, 32'h1);
    chk("t5b_no_push", {31'b0, m_valid}, 32'h0);
    chk("t5b_idle", {31'b0, busy}, 32'h0);
    chk("t5b_sready", {31'b0, s_ready}, 32'h0);
    apply_reset;

    // 6: reset mid-WAIT with two results buffered
    accept(8'h11);
    finish_same(16'h0011);
    accept(8'h22);
    finish_same(16'h0022);
    accept(8'h33);
    hls_ready = 1'b1;
    tick;
    hls_ready = 1'b0;
    chk("t6_in_wait", {30'b0, busy, hls_start}, 32'h2);
    chk("t6_buffered", {16'b0, m_data}, 32'h0011);
    #3;
    apply_reset;
    chk("t6_fifo_empty", {31'b0, m_valid}, 32'h0);
    accept(8'h09);
    finish_same(16'h0099);
    chk("t6_resume", {16'b0, m_data}, 32'h0099);
    chk("t6_resume_err", {31'b0, err}, 32'h0);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;

    // 4: watchdog with one result already buffered
    accept(8'h01);
    finish_same(16'h000a);
    accept(8'h02);
    repeat (254) tick;
    chk("t4_pre_start", {31'b0, hls_start}, 32'h1);
    chk("t4_pre_err", {31'b0, err}, 32'h0);
    tick;
    chk("t4_err", {31'b0, err}, 32'h1);
    chk("t4_start_off", {31'b0, hls_start}, 32'h0);
    chk("t4_idle", {31'b0, busy}, 32'h0);
    s_valid = 1'b1; s_data = 8'h04;
    repeat (3) tick;
    chk("t4_sready_low", {31'b0, s_ready}, 32'h0);
    chk("t4_no_restart", {31'b0, hls_start}, 32'h0);
    s_valid = 1'b0;
    chk("t4_drain_head", {16'b0, m_data}, 32'h000a);
    chk("t4_drain_valid", {31'b0, m_valid}, 32'h1);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("t4_drained", {31'b0, m_valid}, 32'h0);
    chk("t4_err_sticky", {31'b0, err}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
